// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz raster timing generator: pixel/line counters, sync, blank and frame markers.
// Define SYNC_DELAY_EN to register the decoded outputs through PIPE_DEPTH stages.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DEPTH = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       active,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

    // Order of the packed sync bundle: {hs, vs, active, line_start, frame_start}
    localparam logic [4:0] SYNC_IDLE  = 5'b11000;

    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_depth_check
        $error("vga_timing_gen: PIPE_DEPTH must be 1..4");
    end

    logic hs_d;
    logic vs_d;
    logic active_d;
    logic line_start_d;
    logic frame_start_d;
    logic [4:0] sync_d;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= '0;
            DrawY       <= '0;
            frame_count <= '0;
        end else if (DrawX == H_MAX) begin
            DrawX <= '0;
            if (DrawY == V_MAX) begin
                DrawY       <= '0;
                frame_count <= frame_count + 8'd1;
            end else begin
                DrawY <= DrawY + 10'd1;
            end
        end else begin
            DrawX <= DrawX + 10'd1;
        end
    end

    always_comb begin
        hs_d          = !((DrawX >= HS_START) && (DrawX < HS_END));
        vs_d          = !((DrawY >= VS_START) && (DrawY < VS_END));
        active_d      = (DrawX < H_VIS_END) && (DrawY < V_VIS_END);
        line_start_d  = (DrawX == 10'd0);
        frame_start_d = (DrawX == 10'd0) && (DrawY == 10'd0);
    end

    assign sync_d = {hs_d, vs_d, active_d, line_start_d, frame_start_d};

`ifdef SYNC_DELAY_EN
    // Delay line so sync lines up with the sprite stages' registered colour output
    logic [4:0] sync_pipe [PIPE_DEPTH];

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                sync_pipe[i] <= SYNC_IDLE;
            end
        end else begin
            sync_pipe[0] <= sync_d;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    assign {hs, vs, active, line_start, frame_start} = sync_pipe[PIPE_DEPTH-1];
`else
    assign {hs, vs, active, line_start, frame_start} = sync_d;
`endif

endmodule
